aes_sbox_scheduler: RTL

Time-multiplexes one shared 32-bit S-box bank (4 parallel byte lookups, combinational, external to this block) between two requesters.
- Cipher-state path: full 128-bit SubBytes over 4 beats.
- Key-expansion path: single 32-bit SubWord in 1 beat.
- Sits between the round controller / key schedule and the S-box bank, so the iterative AES core needs only one S-box instance.

---
 rtl/aes_sbox_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/aes_sbox_scheduler.sv
// Shares one 32-bit S-box bank between a 4-beat SubBytes state path and a 1-beat SubWord key path.
// Optional AES_SBOX_SCHED_STATS_EN adds a saturating key pre-emption counter output (preempt_cnt).
module aes_sbox_scheduler #(
  parameter bit KEY_PRIO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_req_data,
  output logic         kw_rsp_valid,
  output logic [31:0]  kw_rsp_data,
  output logic [31:0]  sb_in,
  input  logic [31:0]  sb_out,
`ifdef AES_SBOX_SCHED_STATS_EN
  output logic [15:0]  preempt_cnt,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [3:0][31:0] st_in_q, st_in_d;
  logic [3:0][31:0] res_q, res_d;
  logic            kw_vld_q, kw_vld_d;
  logic [31:0]     kw_dat_q, kw_dat_d;
  logic            kgrant_q;
  logic            kw_grant;
  logic            beat_en;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    st_in_d      = st_in_q;
    res_d        = res_q;
    kw_dat_d     = kw_dat_q;
    st_req_ready = 1'b0;
    kw_req_ready = 1'b0;
    sb_in        = '0;

    case (state_q)
      IDLE: begin
        st_req_ready = 1'b1;
        kw_req_ready = 1'b1;
        if (st_req_valid) begin
          st_in_d = st_req_data;
          beat_d  = 2'd0;
          state_d = RUN;
        end
      end
      RUN:  kw_req_ready = KEY_PRIO & ~kgrant_q;
      DONE: begin
        kw_req_ready = 1'b1;
        if (st_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A key grant owns the bank for the cycle; the state beat simply stalls.
    kw_grant = kw_req_valid & kw_req_ready;
    beat_en  = (state_q == RUN) & ~kw_grant;
    kw_vld_d = kw_grant;

    if (kw_grant) begin
      sb_in    = kw_req_data;
      kw_dat_d = sb_out;
    end else if (beat_en) begin
      sb_in                 = st_in_q[2'd3 - beat_q];
      res_d[2'd3 - beat_q]  = sb_out;
      beat_d                = beat_q + 2'd1;
      if (beat_q == 2'd3) state_d = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      st_in_q  <= '0;
      res_q    <= '0;
      kw_vld_q <= 1'b0;
      kw_dat_q <= '0;
      kgrant_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      st_in_q  <= st_in_d;
      res_q    <= res_d;
      kw_vld_q <= kw_vld_d;
      kw_dat_q <= kw_dat_d;
      kgrant_q <= kw_grant;
    end
  end

`ifdef AES_SBOX_SCHED_STATS_EN
  logic [15:0] pcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else if (kw_grant && (state_q == RUN) && (pcnt_q != 16'hFFFF)) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign preempt_cnt = pcnt_q;
`endif

  assign st_rsp_valid = (state_q == DONE);
  assign st_rsp_data  = res_q;
  assign kw_rsp_valid = kw_vld_q;
  assign kw_rsp_data  = kw_dat_q;
  assign busy         = (state_q != IDLE);

endmodule
